// File: rtl/shift_add_mult_seq_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
package mult_seq_pkg;

    // Sequencer states; the unused code 2'd3 is treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;

    // Iteration counter width: must hold the value WIDTH, not just WIDTH-1.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/shift_add_mult_seq_if.sv
// Operand/result handshake bundle for the multiplier sequencer.
interface shift_add_mult_seq_if
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/shift_add_mult_seq_ripple_adder.sv
// Combinational ripple-carry adder built from half/full-adder cells.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module ripple_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    // c[i] is the carry out of bit i.
    logic [WIDTH-1:0] c;

    // Bit 0 has no carry-in, so it uses a half adder; the rest ripple.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_ha
            half_adder u_ha (.x(x[i]), .y(y[i]), .s(s[i]), .c(c[i]));
        end else begin : g_fa
            full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i-1]), .s(s[i]), .co(c[i]));
        end
    end

    assign cout = c[WIDTH-1];
endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned multiplier: one shared adder, WIDTH shift-and-add passes.
module shift_add_mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_mult_seq_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_y;
    logic [WIDTH-1:0]     add_s;
    logic                 add_c;

    // Partial product: add the multiplicand to the upper half when the LSB is set.
    assign add_y = acc_q[0] ? mcand_q : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (acc_q[2*WIDTH-1:WIDTH]),
        .y    (add_y),
        .s    (add_s),
        .cout (add_c)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        product_d   = product_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mcand_d    = bus.a;
                    acc_d      = {{WIDTH{1'b0}}, bus.b};
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Carry lands in the top bit, so the 2W-bit product never overflows.
                acc_d = {add_c, add_s, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // First DONE cycle publishes the result; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    product_d   = acc_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                // Illegal encoding recovers to an idle, ready sequencer.
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            product_q   <= product_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = product_q;

endmodule
